// File: rtl/unidade_controle_jogo.sv
// Game distribution controller: draws a seed, loads it, then walks five
// players through hide/reveal of their class before signalling completion.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// INICIAL  | clear seed counter, player counter and seed register
// SORTEIA  | free-run the seed counter until the start button is pressed
// ESPERA   | wait one cycle for the seed ROM read
// REGISTRA | load the seed register from the ROM
// PREPARA  | clear the player counter
// ESCONDE  | current player's class hidden, wait for next button
// REVELA   | current player's class shown, wait for next button
// AVANCA   | move to the next player, or finish after the last one
// FIM      | distribution done, start button begins a new game
module unidade_controle_jogo (
  input  logic       clock,
  input  logic       rst_global_n,
  input  logic       iniciar,
  input  logic       proximo,
  input  logic       CJ_fim,
  output logic       rst_global,
  output logic       zera_CS,
  output logic       inc_seed,
  output logic       e_seed_reg,
  output logic       zera_CJ,
  output logic       inc_jogador,
  output logic       mostra_classe,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    SORTEIA  = 4'd1,
    ESPERA   = 4'd2,
    REGISTRA = 4'd3,
    PREPARA  = 4'd4,
    ESCONDE  = 4'd5,
    REVELA   = 4'd6,
    AVANCA   = 4'd7,
    FIM      = 4'd8
  } state_t;

  state_t state;
  state_t next_state;

  logic iniciar_prev;
  logic proximo_prev;
  logic iniciar_pulse;
  logic proximo_pulse;

  // Previous button levels; reset to 1 so a button held through reset
  // does not count as a fresh press.
  always_ff @(posedge clock) begin
    if (!rst_global_n) begin
      iniciar_prev <= 1'b1;
      proximo_prev <= 1'b1;
    end else begin
      iniciar_prev <= iniciar;
      proximo_prev <= proximo;
    end
  end

  assign iniciar_pulse = iniciar & ~iniciar_prev;
  assign proximo_pulse = proximo & ~proximo_prev;

  // State register.
  always_ff @(posedge clock) begin
    if (!rst_global_n) begin
      state <= INICIAL;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; each state only looks at the pulse it cares about,
  // so a simultaneous press of the other button is simply dropped.
  always_comb begin
    next_state = INICIAL;
    case (state)
      INICIAL:  next_state = SORTEIA;
      SORTEIA:  next_state = iniciar_pulse ? ESPERA : SORTEIA;
      ESPERA:   next_state = REGISTRA;
      REGISTRA: next_state = PREPARA;
      PREPARA:  next_state = ESCONDE;
      ESCONDE:  next_state = proximo_pulse ? REVELA : ESCONDE;
      REVELA:   next_state = proximo_pulse ? AVANCA : REVELA;
      AVANCA:   next_state = CJ_fim ? FIM : ESCONDE;
      FIM:      next_state = iniciar_pulse ? INICIAL : FIM;
      default:  next_state = INICIAL;
    endcase
  end

  // Output decode from the current state; inc_jogador is suppressed on the
  // last player so the player counter never wraps.
  always_comb begin
    rst_global    = 1'b0;
    zera_CS       = 1'b0;
    inc_seed      = 1'b0;
    e_seed_reg    = 1'b0;
    zera_CJ       = 1'b0;
    inc_jogador   = 1'b0;
    mostra_classe = 1'b0;
    pronto        = 1'b0;
    case (state)
      INICIAL: begin
        rst_global = 1'b1;
        zera_CS    = 1'b1;
        zera_CJ    = 1'b1;
      end
      SORTEIA:  inc_seed      = 1'b1;
      REGISTRA: e_seed_reg    = 1'b1;
      PREPARA:  zera_CJ       = 1'b1;
      REVELA:   mostra_classe = 1'b1;
      AVANCA:   inc_jogador   = ~CJ_fim;
      FIM:      pronto        = 1'b1;
      default: ;
    endcase
  end

  assign db_estado = state;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Bench for unidade_controle_jogo: directed game scenarios followed by random
// button/reset traffic, compared cycle by cycle against a reference model.
module tb_unidade_controle_jogo;

  logic       clock = 1'b0;
  logic       rst_global_n;
  logic       iniciar;
  logic       proximo;
  logic       CJ_fim;
  logic       rst_global;
  logic       zera_CS;
  logic       inc_seed;
  logic       e_seed_reg;
  logic       zera_CJ;
  logic       inc_jogador;
  logic       mostra_classe;
  logic       pronto;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;

  // reference model
  int m_state = 0;
  bit m_ini_prev = 1'b1;
  bit m_prox_prev = 1'b1;

  // datapath stand-in driven by the DUT's own control outputs
  int dp_seed = 0;
  int dp_cap = -1;
  int dp_player = 0;
  int dp_incs = 0;
  bit dp_wrapped = 1'b0;

  unidade_controle_jogo dut (
    .clock(clock),
    .rst_global_n(rst_global_n),
    .iniciar(iniciar),
    .proximo(proximo),
    .CJ_fim(CJ_fim),
    .rst_global(rst_global),
    .zera_CS(zera_CS),
    .inc_seed(inc_seed),
    .e_seed_reg(e_seed_reg),
    .zera_CJ(zera_CJ),
    .inc_jogador(inc_jogador),
    .mostra_classe(mostra_classe),
    .pronto(pronto),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs {rst_global,zera_CS,inc_seed,e_seed_reg,zera_CJ,
  // inc_jogador,mostra_classe,pronto} for each game phase.
  function automatic logic [7:0] exp_out(input int s, input bit cj);
    case (s)
      0: return 8'b1100_1000;
      1: return 8'b0010_0000;
      3: return 8'b0001_0000;
      4: return 8'b0000_1000;
      6: return 8'b0000_0010;
      7: return cj ? 8'b0000_0000 : 8'b0000_0100;
      8: return 8'b0000_0001;
      default: return 8'b0000_0000;
    endcase
  endfunction

  // Game rules: which phase follows, given the presses seen this cycle.
  function automatic int next_phase(input int s, input bit ip, input bit pp, input bit cj);
    case (s)
      0: return 1;
      1: return ip ? 2 : 1;
      2: return 3;
      3: return 4;
      4: return 5;
      5: return pp ? 6 : 5;
      6: return pp ? 7 : 6;
      7: return cj ? 8 : 5;
      8: return ip ? 0 : 8;
      default: return 0;
    endcase
  endfunction

  // One clock: advance model and datapath from pre-edge values, then check.
  task automatic tick();
    bit ip;
    bit pp;
    int n_state;
    int n_seed;
    int n_cap;
    int n_player;
    int n_incs;
    n_seed = dp_seed;
    n_cap = dp_cap;
    n_player = dp_player;
    n_incs = dp_incs;
    if (zera_CS === 1'b1) n_seed = 0;
    else if (inc_seed === 1'b1) begin
      if (dp_seed == 19) dp_wrapped = 1'b1;
      n_seed = (dp_seed + 1) % 20;
    end
    if (rst_global === 1'b1) n_cap = -1;
    else if (e_seed_reg === 1'b1) n_cap = dp_seed;
    if (zera_CJ === 1'b1) begin
      n_player = 0;
      n_incs = 0;
    end else if (inc_jogador === 1'b1) begin
      n_player = dp_player + 1;
      n_incs = dp_incs + 1;
    end
    if (!rst_global_n) begin
      n_state = 0;
      m_ini_prev = 1'b1;
      m_prox_prev = 1'b1;
    end else begin
      ip = iniciar && !m_ini_prev;
      pp = proximo && !m_prox_prev;
      n_state = next_phase(m_state, ip, pp, CJ_fim);
      m_ini_prev = iniciar;
      m_prox_prev = proximo;
    end
    @(posedge clock);
    #1;
    m_state = n_state;
    dp_seed = n_seed;
    dp_cap = n_cap;
    dp_player = n_player;
    dp_incs = n_incs;
    CJ_fim = (dp_player == 4);
    #1;
    chk("state", db_estado, m_state);
    chk("outputs", {rst_global, zera_CS, inc_seed, e_seed_reg, zera_CJ,
                    inc_jogador, mostra_classe, pronto}, exp_out(m_state, CJ_fim));
  endtask

  task automatic press_proximo();
    proximo = 1'b1;
    tick();
    proximo = 1'b0;
    tick();
  endtask

  initial begin
    bit found;
    rst_global_n = 1'b0;
    iniciar = 1'b0;
    proximo = 1'b0;
    CJ_fim = 1'b0;

    // reset, then free-running seed draw
    tick();
    tick();
    chk("reset_state", db_estado, 0);
    rst_global_n = 1'b1;
    tick();
    chk("sorteia_entry", db_estado, 1);
    for (int i = 0; i < 25; i++) tick();
    chk("seed_wrap", dp_wrapped, 1);

    // start while the counter holds 6; captured address must be 7
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (dp_seed == 6) found = 1'b1;
      else tick();
    end
    chk("seed6_timeout", found, 1);
    iniciar = 1'b1;
    tick();
    chk("espera", db_estado, 2);
    iniciar = 1'b0;
    tick();
    chk("registra", db_estado, 3);
    tick();
    chk("prepara", db_estado, 4);
    chk("seed_capture", dp_cap, 7);
    tick();
    chk("esconde", db_estado, 5);

    // held next button gives one transition only
    proximo = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("hold_proximo", db_estado, 6);
    proximo = 1'b0;
    tick();

    // both buttons together in REVELA: next wins
    iniciar = 1'b1;
    proximo = 1'b1;
    tick();
    chk("both_revela", db_estado, 7);
    iniciar = 1'b0;
    proximo = 1'b0;
    tick();

    // remaining presses 3..10 finish the round
    for (int i = 3; i <= 10; i++) press_proximo();
    chk("fim_state", db_estado, 8);
    chk("pronto", pronto, 1);
    chk("inc_jogador_count", dp_incs, 4);

    press_proximo();
    chk("fim_ignores_proximo", db_estado, 8);
    iniciar = 1'b1;
    tick();
    chk("restart", db_estado, 0);
    iniciar = 1'b0;
    tick();
    tick();
    tick();

    // both buttons together in SORTEIA: start wins
    iniciar = 1'b1;
    proximo = 1'b1;
    tick();
    chk("both_sorteia", db_estado, 2);
    iniciar = 1'b0;
    proximo = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    press_proximo();
    chk("revela_again", db_estado, 6);

    // reset mid-round with start held: no spurious press afterwards
    iniciar = 1'b1;
    rst_global_n = 1'b0;
    tick();
    chk("reset_midround", db_estado, 0);
    rst_global_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("held_start_ignored", db_estado, 1);
    iniciar = 1'b0;
    tick();
    iniciar = 1'b1;
    tick();
    chk("fresh_start", db_estado, 2);
    iniciar = 1'b0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_global_n = ($urandom_range(0, 199) != 0);
      iniciar = ($urandom_range(0, 3) == 0);
      proximo = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
